// File: rtl/hazard_ctrl_unit_if.sv
// Signal bundle between the hazard unit and the pipeline / cache side.
// The hazard unit connects through the slave modport; whoever drives the
// pipeline status (datapath or testbench) uses the master modport.
interface hazard_ctrl_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // Pipeline and cache status
    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic [1:0]       pc_src;
    logic [REG_W-1:0] rsel1;
    logic [REG_W-1:0] rsel2;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_wsel;
    logic             ex_dren;
    logic [REG_W-1:0] mem_wsel;
    logic             mem_wen;
    logic [REG_W-1:0] wb_wsel;
    logic             wb_wen;

    // Latch control, forwarding and performance counters
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             flushed;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  ihit, dhit, mem_dren, mem_dwen, pc_src, rsel1, rsel2,
               ex_rs, ex_rt, ex_wsel, ex_dren, mem_wsel, mem_wen,
               wb_wsel, wb_wen,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b,
               flushed, stall_cnt, flush_cnt
    );

    modport master (
        output ihit, dhit, mem_dren, mem_dwen, pc_src, rsel1, rsel2,
               ex_rs, ex_rt, ex_wsel, ex_dren, mem_wsel, mem_wen,
               wb_wsel, wb_wen,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b,
               flushed, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage pipeline: latch enables/flushes, EX-stage
// forwarding selects, multi-cycle load-use stalls, branch squash, data-miss
// freeze, plus saturating stall/flush counters.
// Priority each cycle: data miss > control transfer > load-use > fetch miss.
module hazard_ctrl_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_FLUSH = 2,
    parameter int CNT_W    = 16
) (
    input logic               CLK,
    input logic               nRST,
    hazard_ctrl_unit_if.slave hz
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DWAIT   = 2'd2
    } state_e;

    // Remaining bubbles loaded when a load-use hazard first appears; the
    // detection cycle itself is the first bubble.
    localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;    // state to resume once a data miss clears
    state_e           eff;             // state whose rules apply this cycle
    logic [2:0]       lat_q, lat_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic dmiss, luse, br;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush, flushed;
    logic [1:0] fwd_a, fwd_b;

    // MEM result wins over WB; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             m_wen,
        input logic [REG_W-1:0] m_wsel,
        input logic             w_wen,
        input logic [REG_W-1:0] w_wsel
    );
        if (m_wen && (m_wsel != '0) && (m_wsel == src)) begin
            return 2'd1;
        end else if (w_wen && (w_wsel != '0) && (w_wsel == src)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign dmiss = (hz.mem_dren | hz.mem_dwen) & ~hz.dhit;
    assign luse  = hz.ex_dren & (hz.ex_wsel != '0) &
                   ((hz.ex_wsel == hz.rsel1) | (hz.ex_wsel == hz.rsel2));
    assign br    = (hz.pc_src != 2'd0);

    // Forwarding selects are independent of the stall state machine.
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (nRST) begin
            fwd_a = fwd_sel(hz.ex_rs, hz.mem_wen, hz.mem_wsel, hz.wb_wen, hz.wb_wsel);
            fwd_b = fwd_sel(hz.ex_rt, hz.mem_wen, hz.mem_wsel, hz.wb_wen, hz.wb_wsel);
        end
    end

    // Next-state and latch control; a data miss freezes everything upstream
    // of MEM/WB and keeps the interrupted stall (state + lat_cnt) intact.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        lat_d       = lat_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        flushed     = 1'b0;

        case (state_q)
            LDSTALL: eff = LDSTALL;
            DWAIT:   eff = (ret_q == LDSTALL) ? LDSTALL : RUN;
            default: eff = RUN;
        endcase

        if (dmiss) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            state_d     = DWAIT;
            ret_d       = eff;
        end else if (br) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = (BR_FLUSH >= 2);
            flushed    = 1'b1;
            state_d    = RUN;
            lat_d      = 3'd0;
        end else if (eff == LDSTALL) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_flush = 1'b1;
            if (lat_q <= 3'd1) begin
                state_d = RUN;
                lat_d   = 3'd0;
            end else begin
                state_d = LDSTALL;
                lat_d   = lat_q - 3'd1;
            end
        end else if (luse) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = LDSTALL;
                lat_d   = LAT_INIT;
            end else begin
                state_d = RUN;
            end
        end else if (!hz.ihit) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            state_d = RUN;
        end

        if (!nRST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, memwb_flush, flushed} = 4'b0000;
        end
    end

    // State register; reset abandons any stall or miss in progress.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            ret_q   <= RUN;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            lat_q   <= lat_d;
        end
    end

    // Saturating performance counters: stalled PC cycles and taken transfers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flushed && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.ifid_en     = ifid_en;
    assign hz.idex_en     = idex_en;
    assign hz.exmem_en    = exmem_en;
    assign hz.memwb_en    = memwb_en;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.memwb_flush = memwb_flush;
    assign hz.flushed     = flushed;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances share one stimulus stream.
// u1: LOAD_LAT=3, BR_FLUSH=2, CNT_W=16.  u2: LOAD_LAT=1, BR_FLUSH=1, CNT_W=3.
module tb_hazard_ctrl_unit;

    typedef struct packed {
        logic       ihit, dhit, mem_dren, mem_dwen;
        logic [1:0] pc_src;
        logic [4:0] rsel1, rsel2, ex_rs, ex_rt, ex_wsel;
        logic       ex_dren;
        logic [4:0] mem_wsel;
        logic       mem_wen;
        logic [4:0] wb_wsel;
        logic       wb_wen;
    } in_t;

    typedef struct packed {
        logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
        logic       ifid_flush, idex_flush, memwb_flush, flushed;
        logic [1:0] fwd_a, fwd_b;
    } exp_t;

    typedef struct {
        in_t   i;
        exp_t  e;
        string nm;
    } vec_t;

    localparam exp_t ZERO  = 13'b0;
    localparam exp_t NORM  = {5'b11111, 4'b0000, 4'b0000};
    localparam exp_t STALL = {5'b00111, 4'b0100, 4'b0000};
    localparam exp_t IMISS = {5'b01111, 4'b1000, 4'b0000};
    localparam exp_t BRF   = {5'b11111, 4'b1101, 4'b0000};
    localparam exp_t BRF1  = {5'b11111, 4'b1001, 4'b0000};
    localparam exp_t FRZ   = {5'b00001, 4'b0010, 4'b0000};

    logic CLK = 1'b0;
    logic nRST = 1'b1;
    always #5 CLK = ~CLK;

    hazard_ctrl_unit_if #(.REG_W(5), .CNT_W(16)) h1 ();
    hazard_ctrl_unit_if #(.REG_W(5), .CNT_W(3))  h2 ();

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .BR_FLUSH(2), .CNT_W(16)) u1 (
        .CLK(CLK), .nRST(nRST), .hz(h1));
    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .BR_FLUSH(1), .CNT_W(3)) u2 (
        .CLK(CLK), .nRST(nRST), .hz(h2));

    assign h2.ihit     = h1.ihit;
    assign h2.dhit     = h1.dhit;
    assign h2.mem_dren = h1.mem_dren;
    assign h2.mem_dwen = h1.mem_dwen;
    assign h2.pc_src   = h1.pc_src;
    assign h2.rsel1    = h1.rsel1;
    assign h2.rsel2    = h1.rsel2;
    assign h2.ex_rs    = h1.ex_rs;
    assign h2.ex_rt    = h1.ex_rt;
    assign h2.ex_wsel  = h1.ex_wsel;
    assign h2.ex_dren  = h1.ex_dren;
    assign h2.mem_wsel = h1.mem_wsel;
    assign h2.mem_wen  = h1.mem_wen;
    assign h2.wb_wsel  = h1.wb_wsel;
    assign h2.wb_wen   = h1.wb_wen;

    exp_t act1, act2;
    assign act1 = {h1.pc_en, h1.ifid_en, h1.idex_en, h1.exmem_en, h1.memwb_en,
                   h1.ifid_flush, h1.idex_flush, h1.memwb_flush, h1.flushed,
                   h1.fwd_a, h1.fwd_b};
    assign act2 = {h2.pc_en, h2.ifid_en, h2.idex_en, h2.exmem_en, h2.memwb_en,
                   h2.ifid_flush, h2.idex_flush, h2.memwb_flush, h2.flushed,
                   h2.fwd_a, h2.fwd_b};

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bubbles still owed, plus plain integer counters.
    int m_ll[2]   = '{3, 1};
    int m_bf[2]   = '{2, 1};
    int m_cmax[2] = '{65535, 7};
    int m_owed[2] = '{0, 0};
    int m_scnt[2] = '{0, 0};
    int m_fcnt[2] = '{0, 0};

    in_t IDLE;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] r, input in_t x);
        if (x.mem_wen && x.mem_wsel != 0 && x.mem_wsel == r) return 2'd1;
        if (x.wb_wen && x.wb_wsel != 0 && x.wb_wsel == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t predict(input int k, input in_t x);
        exp_t e;
        logic dm, lu;
        e  = '0;
        dm = (x.mem_dren || x.mem_dwen) && !x.dhit;
        lu = x.ex_dren && x.ex_wsel != 0 && (x.ex_wsel == x.rsel1 || x.ex_wsel == x.rsel2);
        e.fwd_a = ref_fwd(x.ex_rs, x);
        e.fwd_b = ref_fwd(x.ex_rt, x);
        if (dm) begin
            e.memwb_en = 1'b1; e.memwb_flush = 1'b1;
        end else if (x.pc_src != 0) begin
            {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en, e.memwb_en} = 5'b11111;
            e.ifid_flush = 1'b1; e.idex_flush = (m_bf[k] >= 2); e.flushed = 1'b1;
        end else if (m_owed[k] > 0 || lu) begin
            {e.idex_en, e.exmem_en, e.memwb_en} = 3'b111;
            e.idex_flush = 1'b1;
        end else if (!x.ihit) begin
            {e.ifid_en, e.idex_en, e.exmem_en, e.memwb_en} = 4'b1111;
            e.ifid_flush = 1'b1;
        end else begin
            {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en, e.memwb_en} = 5'b11111;
        end
        return e;
    endfunction

    task automatic model_step(input int k, input in_t x);
        exp_t e;
        logic dm, lu;
        e  = predict(k, x);
        dm = (x.mem_dren || x.mem_dwen) && !x.dhit;
        lu = x.ex_dren && x.ex_wsel != 0 && (x.ex_wsel == x.rsel1 || x.ex_wsel == x.rsel2);
        if (!e.pc_en && m_scnt[k] < m_cmax[k]) m_scnt[k]++;
        if (e.flushed && m_fcnt[k] < m_cmax[k]) m_fcnt[k]++;
        if (dm) begin
        end else if (x.pc_src != 0) m_owed[k] = 0;
        else if (m_owed[k] > 0) m_owed[k]--;
        else if (lu) m_owed[k] = m_ll[k] - 1;
    endtask

    task automatic drive(input in_t x);
        h1.ihit = x.ihit;         h1.dhit = x.dhit;
        h1.mem_dren = x.mem_dren; h1.mem_dwen = x.mem_dwen;
        h1.pc_src = x.pc_src;     h1.rsel1 = x.rsel1;     h1.rsel2 = x.rsel2;
        h1.ex_rs = x.ex_rs;       h1.ex_rt = x.ex_rt;     h1.ex_wsel = x.ex_wsel;
        h1.ex_dren = x.ex_dren;   h1.mem_wsel = x.mem_wsel; h1.mem_wen = x.mem_wen;
        h1.wb_wsel = x.wb_wsel;   h1.wb_wen = x.wb_wen;
    endtask

    // Apply one cycle of inputs, compare both DUTs to the model before the edge.
    task automatic drive_chk(input in_t x, input string nm);
        @(negedge CLK);
        drive(x);
        #1;
        chk({nm, "/u1_out"},  32'(act1), 32'(predict(0, x)));
        chk({nm, "/u1_scnt"}, 32'(h1.stall_cnt), m_scnt[0]);
        chk({nm, "/u1_fcnt"}, 32'(h1.flush_cnt), m_fcnt[0]);
        chk({nm, "/u2_out"},  32'(act2), 32'(predict(1, x)));
        chk({nm, "/u2_scnt"}, 32'(h2.stall_cnt), m_scnt[1]);
        chk({nm, "/u2_fcnt"}, 32'(h2.flush_cnt), m_fcnt[1]);
        model_step(0, x);
        model_step(1, x);
    endtask

    function automatic in_t fw(input logic [4:0] rs, input logic [4:0] rt,
                               input logic mw, input logic [4:0] ms,
                               input logic ww, input logic [4:0] ws);
        in_t x;
        x = IDLE;
        x.ex_rs = rs; x.ex_rt = rt;
        x.mem_wen = mw; x.mem_wsel = ms;
        x.wb_wen = ww;  x.wb_wsel = ws;
        return x;
    endfunction

    function automatic exp_t with_fwd(input exp_t e, input logic [1:0] a, input logic [1:0] b);
        exp_t r;
        r = e; r.fwd_a = a; r.fwd_b = b;
        return r;
    endfunction

    // Asynchronous reset mid-cycle, held three cycles with forwarding inputs live.
    task automatic do_reset();
        in_t x;
        x = fw(5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 5'd8);
        @(negedge CLK);
        drive(x);
        #2 nRST = 1'b0;
        #1;
        chk("rst_async/u1_out", 32'(act1), 32'(ZERO));
        repeat (3) begin
            @(negedge CLK);
            #1;
            chk("rst/u1_out",  32'(act1), 32'(ZERO));
            chk("rst/u2_out",  32'(act2), 32'(ZERO));
            chk("rst/u1_scnt", 32'(h1.stall_cnt), 32'd0);
            chk("rst/u1_fcnt", 32'(h1.flush_cnt), 32'd0);
        end
        nRST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_owed[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end
        model_step(0, x);
        model_step(1, x);
    endtask

    function automatic in_t rnd_in();
        in_t x;
        x.ihit     = ($urandom_range(0, 9) < 8);
        x.dhit     = ($urandom_range(0, 9) < 6);
        x.mem_dren = ($urandom_range(0, 9) < 2);
        x.mem_dwen = ($urandom_range(0, 9) < 1);
        x.pc_src   = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom_range(1, 3));
        x.rsel1    = 5'($urandom_range(0, 3));
        x.rsel2    = 5'($urandom_range(0, 3));
        x.ex_rs    = 5'($urandom_range(0, 3));
        x.ex_rt    = 5'($urandom_range(0, 3));
        x.ex_wsel  = 5'($urandom_range(0, 3));
        x.ex_dren  = ($urandom_range(0, 9) < 3);
        x.mem_wsel = 5'($urandom_range(0, 3));
        x.mem_wen  = 1'($urandom_range(0, 1));
        x.wb_wsel  = 5'($urandom_range(0, 3));
        x.wb_wen   = 1'($urandom_range(0, 1));
        return x;
    endfunction

    initial begin
        in_t x, lu, miss;
        IDLE = '0;
        IDLE.ihit = 1'b1;
        lu = IDLE; lu.ex_dren = 1'b1; lu.ex_wsel = 5'd4; lu.rsel1 = 5'd7; lu.rsel2 = 5'd4;
        miss = IDLE; miss.mem_dren = 1'b1; miss.dhit = 1'b0;

        // Single-cycle vectors (no state left behind between rows)
        vt[0] = '{IDLE, NORM, "normal"};
        vt[1] = '{fw(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 5'd8), with_fwd(NORM, 2'd1, 2'd0), "fwd_mem"};
        vt[2] = '{fw(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 5'd8), with_fwd(NORM, 2'd2, 2'd0), "fwd_wb"};
        vt[3] = '{fw(5'd1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3), with_fwd(NORM, 2'd0, 2'd1), "fwdb_pri"};
        vt[4] = '{fw(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0), NORM, "fwd_r0"};
        vt[5] = '{fw(5'd5, 5'd6, 1'b0, 5'd5, 1'b0, 5'd6), NORM, "fwd_wen_off"};
        x = IDLE; x.ihit = 1'b0;
        vt[6] = '{x, IMISS, "imiss"};
        x = IDLE; x.mem_dwen = 1'b1; x.dhit = 1'b0;
        vt[7] = '{x, FRZ, "dmiss_st"};
        x.dhit = 1'b1;
        vt[8] = '{x, NORM, "dmiss_done"};
        x = IDLE; x.ex_dren = 1'b1; x.ex_wsel = 5'd0;
        vt[9] = '{x, NORM, "luse_r0"};

        drive(IDLE);
        do_reset();
        drive_chk(IDLE, "rel");
        chk("rel/u1_out", 32'(act1), 32'(NORM));
        chk("rel/u1_scnt", 32'(h1.stall_cnt), 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive_chk(vt[i].i, vt[i].nm);
            chk({vt[i].nm, "/tbl"}, 32'(act1), 32'(vt[i].e));
        end

        // Load-use with three bubbles
        do_reset();
        drive_chk(lu, "lu1");     chk("lu1/tbl", 32'(act1), 32'(STALL));
        chk("lu1/u2", 32'(act2), 32'(STALL));
        drive_chk(IDLE, "lu2");   chk("lu2/tbl", 32'(act1), 32'(STALL));
        chk("lu2/u2", 32'(act2), 32'(NORM));
        drive_chk(IDLE, "lu3");   chk("lu3/tbl", 32'(act1), 32'(STALL));
        drive_chk(IDLE, "lu_end"); chk("lu_end/tbl", 32'(act1), 32'(NORM));
        chk("lu_end/scnt", 32'(h1.stall_cnt), 32'd3);

        // Taken branch during a fetch miss
        do_reset();
        x = IDLE; x.ihit = 1'b0; x.pc_src = 2'd1;
        drive_chk(x, "br");       chk("br/tbl", 32'(act1), 32'(BRF));
        chk("br/u2", 32'(act2), 32'(BRF1));
        drive_chk(IDLE, "br_end"); chk("br_end/tbl", 32'(act1), 32'(NORM));
        chk("br_end/fcnt", 32'(h1.flush_cnt), 32'd1);

        // Data miss holding a jump in EX
        do_reset();
        x = miss; x.pc_src = 2'd2;
        for (int i = 0; i < 4; i++) begin
            drive_chk(x, "dm_jmp"); chk("dm_jmp/tbl", 32'(act1), 32'(FRZ));
        end
        x.dhit = 1'b1;
        drive_chk(x, "dm_rel");   chk("dm_rel/tbl", 32'(act1), 32'(BRF));
        drive_chk(IDLE, "dm_end"); chk("dm_end/tbl", 32'(act1), 32'(NORM));
        chk("dm_end/fcnt", 32'(h1.flush_cnt), 32'd1);
        chk("dm_end/scnt", 32'(h1.stall_cnt), 32'd4);

        // jr cancels a load stall
        do_reset();
        drive_chk(lu, "cx1");     chk("cx1/tbl", 32'(act1), 32'(STALL));
        x = IDLE; x.pc_src = 2'd3;
        drive_chk(x, "cx_jr");    chk("cx_jr/tbl", 32'(act1), 32'(BRF));
        drive_chk(IDLE, "cx_end"); chk("cx_end/tbl", 32'(act1), 32'(NORM));
        chk("cx_end/scnt", 32'(h1.stall_cnt), 32'd1);

        // Data miss in the middle of a load stall keeps the remaining bubbles
        do_reset();
        drive_chk(lu, "ldm1");    chk("ldm1/tbl", 32'(act1), 32'(STALL));
        drive_chk(miss, "ldm_f1"); chk("ldm_f1/tbl", 32'(act1), 32'(FRZ));
        drive_chk(miss, "ldm_f2"); chk("ldm_f2/tbl", 32'(act1), 32'(FRZ));
        x = miss; x.dhit = 1'b1;
        drive_chk(x, "ldm2");     chk("ldm2/tbl", 32'(act1), 32'(STALL));
        drive_chk(IDLE, "ldm3");  chk("ldm3/tbl", 32'(act1), 32'(STALL));
        drive_chk(IDLE, "ldm_end"); chk("ldm_end/tbl", 32'(act1), 32'(NORM));
        chk("ldm_end/scnt", 32'(h1.stall_cnt), 32'd5);

        // Reset in the middle of a stall abandons it
        drive_chk(lu, "rs_lu");   chk("rs_lu/tbl", 32'(act1), 32'(STALL));
        do_reset();
        drive_chk(IDLE, "rs_end"); chk("rs_end/tbl", 32'(act1), 32'(NORM));

        // Counter saturation on the narrow instance
        do_reset();
        x = IDLE; x.ihit = 1'b0;
        for (int i = 0; i < 10; i++) drive_chk(x, "sat_s");
        drive_chk(IDLE, "sat_s_end");
        chk("sat_s/u2_scnt", 32'(h2.stall_cnt), 32'd7);
        chk("sat_s/u1_scnt", 32'(h1.stall_cnt), 32'd10);
        x = IDLE; x.pc_src = 2'd1;
        for (int i = 0; i < 9; i++) drive_chk(x, "sat_f");
        drive_chk(IDLE, "sat_f_end");
        chk("sat_f/u2_fcnt", 32'(h2.flush_cnt), 32'd7);
        chk("sat_f/u1_fcnt", 32'(h1.flush_cnt), 32'd9);

        // Randomized run against the model, with one reset in the middle
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            drive_chk(rnd_in(), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Second-generation hazard unit for the 5-stage pipeline, replacing the flat combinational hazard logic.
- Generates per-latch enables and flushes, EX-stage forwarding selects, multi-cycle load-use stalls, branch/jump squash and cache-miss freezes.
- Includes saturating stall and flush performance counters.
- Sits between the pipeline latches, the datapath control and the cache interface.

Parameters:
- REG_W, 5: register index width.
- LOAD_LAT, 1: bubble cycles inserted per load-use hazard. Legal range 1..7.
- BR_FLUSH, 2: younger stages squashed on a taken branch or jump. 1 flushes IF/ID only; 2 flushes IF/ID and ID/EX.
- CNT_W, 16: performance counter width.

Ports:
- CLK, in, 1: clock, rising edge.
- nRST, in, 1: asynchronous reset, active low.
- ihit, in, 1: instruction fetch hit.
- dhit, in, 1: data access complete.
- mem_dren, in, 1: load in MEM.
- mem_dwen, in, 1: store in MEM.
- pc_src, in, 2: resolved in EX. 0 = sequential, 1 = branch taken, 2 = jump, 3 = jr.
- rsel1, in, REG_W: ID source register 1.
- rsel2, in, REG_W: ID source register 2.
- ex_rs, in, REG_W: EX source register (rs).
- ex_rt, in, REG_W: EX source register (rt).
- ex_wsel, in, REG_W: EX destination register.
- ex_dren, in, 1: instruction in EX is a load.
- mem_wsel, in, REG_W: MEM destination register.
- mem_wen, in, 1: MEM register write enable.
- wb_wsel, in, REG_W: WB destination register.
- wb_wen, in, 1: WB register write enable.
- pc_en, out, 1: PC enable.
- ifid_en, out, 1: IF/ID latch enable.
- idex_en, out, 1: ID/EX latch enable.
- exmem_en, out, 1: EX/MEM latch enable.
- memwb_en, out, 1: MEM/WB latch enable.
- ifid_flush, out, 1: IF/ID flush.
- idex_flush, out, 1: ID/EX flush.
- memwb_flush, out, 1: MEM/WB flush.
- fwd_a, out, 2: forwarding select for ex_rs.
- fwd_b, out, 2: forwarding select for ex_rt.
- flushed, out, 1: pulses one cycle per taken control transfer.
- stall_cnt, out, CNT_W: count of stall cycles.
- flush_cnt, out, CNT_W: count of taken control transfers.

Behaviour:
- Reset (nRST low, asynchronous):
  - State goes to RUN; internal counter lat_cnt, stall_cnt and flush_cnt go to 0.
  - While nRST is low: all enables 0, all flushes 0, fwd_a/fwd_b 0, flushed 0.
  - Reset asserted mid-stall or mid-miss abandons the operation immediately.
- Control outputs are combinational from state and inputs. Counters are registered.
- Forwarding (independent of state):
  - fwd_a = 1 when mem_wen, mem_wsel != 0 and mem_wsel == ex_rs.
  - Otherwise fwd_a = 2 when wb_wen, wb_wsel != 0 and wb_wsel == ex_rs.
  - Otherwise fwd_a = 0. MEM has priority over WB.
  - fwd_b follows the same rules using ex_rt. Value 3 is never driven.
- Definitions:
  - dmiss = (mem_dren | mem_dwen) & !dhit.
  - luse = ex_dren & ex_wsel != 0 & (ex_wsel == rsel1 | ex_wsel == rsel2).
  - br = pc_src != 0.
- Priority each cycle: dmiss > br > luse/LDSTALL > !ihit > normal.
- dmiss (state DWAIT):
  - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1; flushes 0.
  - Held until dhit, then returns to the prior state with lat_cnt preserved.
  - A branch sitting in EX is held and resolves after the freeze.
- br (takes effect when not in dmiss):
  - All enables 1; pc_en = 1 even if !ihit.
  - ifid_flush = 1; idex_flush = 1 if BR_FLUSH >= 2.
  - flushed = 1; flush_cnt increments.
  - Any LDSTALL in progress is cancelled and the state goes to RUN.
- luse in RUN:
  - pc_en = 0, ifid_en = 0, idex_flush = 1; all other enables 1.
  - If LOAD_LAT > 1: go to LDSTALL with lat_cnt = LOAD_LAT - 1.
- LDSTALL:
  - Same outputs as luse.
  - lat_cnt decrements each cycle; return to RUN in the cycle lat_cnt reaches 1.
  - Total bubbles per hazard = LOAD_LAT.
- !ihit (no higher-priority event):
  - pc_en = 0, ifid_flush = 1, ifid_en = 1; downstream stages advance.
- Normal: all enables 1, all flushes 0.
- stall_cnt increments every cycle in which pc_en = 0 while nRST is high.
- Both counters saturate at all-ones and never wrap.
- States: RUN, LDSTALL, DWAIT. Encoding is free; no illegal-state lockup (default returns to RUN).

Test Plan:
- Reset held 3 cycles, then released with ihit = 1 and no hazards -> during reset all outputs 0; after release all enables 1, fwd_a = fwd_b = 0, counters 0.
- mem_wen = 1, mem_wsel = 8, wb_wen = 1, wb_wsel = 8, ex_rs = 8, ex_rt = 0 -> fwd_a = 1, fwd_b = 0; drop mem_wen -> fwd_a = 2.
- LOAD_LAT = 3, ex_dren = 1, ex_wsel = 4, rsel2 = 4 -> exactly 3 cycles of pc_en = 0 with idex_flush = 1, then RUN; stall_cnt = 3.
- pc_src = 1 with ihit = 0, BR_FLUSH = 2 -> pc_en = 1, ifid_flush = idex_flush = 1, flushed one-cycle pulse, flush_cnt = 1.
- mem_dren = 1, dhit = 0 for 4 cycles with pc_src = 2 -> enables 0, memwb_flush = 1 for 4 cycles, no flush; cycle after dhit -> flushed = 1.
- In LDSTALL (LOAD_LAT = 3) assert pc_src = 3 -> stall cancelled, state RUN. Separately, force stall_cnt to all-ones -> holds without wrap.
